lfsr_encrypt_engine: RTL and testbench

//   Hardware encryption stage that sits directly upstream of the decrypt program.
//   It reads the plaintext message from data memory [0..54] and fetches the selected
//   tap pattern from the pattern table at [55..62].
//   It writes the 64-byte padded ciphertext to [64..127], the exact layout the decrypt

---
 rtl/lfsr_encrypt_engine.sv | 181 ++++++++++++++++++
 tb/tb_lfsr_encrypt_engine.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_encrypt_engine.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_encrypt_engine
// Description : LFSR stream-cipher stage. Reads the tap pattern selected by
//               ptrn_sel and the plaintext message from data memory. Writes a
//               CT_LEN-byte ciphertext to memory, then raises a sticky done.
//               The ciphertext is a space preamble followed by the message,
//               XORed with an 8-bit LFSR keystream.
// Ports       : clk        - system clock, rising edge
//               reset_n    - asynchronous active-low reset
//               start      - one-cycle run request, honoured in IDLE/DONE
//               ptrn_sel   - tap pattern index (0..7)
//               seed       - initial LFSR state (0 is replaced by 8'h01)
//               pre_len    - preamble length (values below 9 become 9)
//               mem_addr   - data memory address
//               mem_rd_en  - read strobe, data on mem_rdata one cycle later
//               mem_wr_en  - write strobe, commits on the same rising edge
//               mem_wdata  - write data, 0 whenever mem_wr_en is low
//               mem_rdata  - synchronous read data
//               busy       - run in progress
//               done       - sticky completion flag
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_encrypt_engine #(
    parameter logic [7:0] MSG_BASE = 8'd0,
    parameter logic [7:0] TAP_BASE = 8'd55,
    parameter logic [7:0] CT_BASE  = 8'd64,
    parameter int         CT_LEN   = 64,
    parameter logic [7:0] PAD_CHAR = 8'h20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [2:0] ptrn_sel,
    input  logic [7:0] seed,
    input  logic [3:0] pre_len,
    output logic [7:0] mem_addr,
    output logic       mem_rd_en,
    output logic       mem_wr_en,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic       busy,
    output logic       done
);

    localparam int               IDX_W    = $clog2(CT_LEN);
    localparam logic [3:0]       MIN_PRE  = 4'd9;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CT_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_TAP_RD   = 3'd1,
        S_TAP_WAIT = 3'd2,
        S_PAD      = 3'd3,
        S_MSG_RD   = 3'd4,
        S_MSG_WAIT = 3'd5,
        S_MSG_WR   = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       lfsr_q,  lfsr_d;
    logic [7:0]       taps_q,  taps_d;
    logic [7:0]       pt_q,    pt_d;
    logic [2:0]       sel_q,   sel_d;
    logic [3:0]       pre_q,   pre_d;
    logic [IDX_W-1:0] idx_q,   idx_d;

    logic             byte_written;
    logic [IDX_W-1:0] idx_inc;

    assign idx_inc = idx_q + IDX_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            lfsr_q  <= 8'd0;
            taps_q  <= 8'd0;
            pt_q    <= 8'd0;
            sel_q   <= 3'd0;
            pre_q   <= 4'd0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            taps_q  <= taps_d;
            pt_q    <= pt_d;
            sel_q   <= sel_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        taps_d       = taps_q;
        pt_d         = pt_q;
        sel_d        = sel_q;
        pre_d        = pre_q;
        idx_d        = idx_q;
        byte_written = 1'b0;
        mem_addr     = 8'd0;
        mem_rd_en    = 1'b0;
        mem_wr_en    = 1'b0;
        mem_wdata    = 8'd0;
        busy         = 1'b0;
        done         = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                done = (state_q == S_DONE);
                // Start in DONE re-arms exactly like start in IDLE.
                if (start) begin
                    sel_d   = ptrn_sel;
                    pre_d   = (pre_len < MIN_PRE) ? MIN_PRE : pre_len;
                    // An all-zero LFSR would lock up, so zero seeds become 1.
                    lfsr_d  = (seed == 8'd0) ? 8'h01 : seed;
                    idx_d   = '0;
                    state_d = S_TAP_RD;
                end
            end
            S_TAP_RD: begin
                busy      = 1'b1;
                mem_rd_en = 1'b1;
                mem_addr  = TAP_BASE + 8'(sel_q);
                state_d   = S_TAP_WAIT;
            end
            S_TAP_WAIT: begin
                busy    = 1'b1;
                taps_d  = mem_rdata;
                state_d = (8'(idx_q) < 8'(pre_q)) ? S_PAD : S_MSG_RD;
            end
            S_PAD: begin
                busy         = 1'b1;
                mem_wr_en    = 1'b1;
                mem_addr     = CT_BASE + 8'(idx_q);
                mem_wdata    = PAD_CHAR ^ lfsr_q;
                byte_written = 1'b1;
            end
            S_MSG_RD: begin
                busy      = 1'b1;
                mem_rd_en = 1'b1;
                // Ciphertext slot i carries plaintext byte i - pre_len.
                mem_addr  = MSG_BASE + 8'(idx_q) - 8'(pre_q);
                state_d   = S_MSG_WAIT;
            end
            S_MSG_WAIT: begin
                busy    = 1'b1;
                pt_d    = mem_rdata;
                state_d = S_MSG_WR;
            end
            S_MSG_WR: begin
                busy         = 1'b1;
                mem_wr_en    = 1'b1;
                mem_addr     = CT_BASE + 8'(idx_q);
                mem_wdata    = pt_q ^ lfsr_q;
                byte_written = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Shared bookkeeping for every ciphertext byte written: step the
        // keystream, advance the index and choose preamble vs message next.
        if (byte_written) begin
            lfsr_d = {lfsr_q[6:0], ^(lfsr_q & taps_q)};
            idx_d  = idx_inc;
            if (idx_q == LAST_IDX) begin
                state_d = S_DONE;
            end else if (8'(idx_inc) < 8'(pre_q)) begin
                state_d = S_PAD;
            end else begin
                state_d = S_MSG_RD;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lfsr_encrypt_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_encrypt_engine
// Description : Self-checking bench for lfsr_encrypt_engine. Holds the data
//               memory, a keystream/ciphertext reference model, a vector
//               table, hand-written corner sequences and randomized runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_encrypt_engine;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       start;
    logic [2:0] ptrn_sel;
    logic [7:0] seed;
    logic [3:0] pre_len;
    logic [7:0] mem_addr;
    logic       mem_rd_en;
    logic       mem_wr_en;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       done;

    lfsr_encrypt_engine dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .ptrn_sel  (ptrn_sel),
        .seed      (seed),
        .pre_len   (pre_len),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done)
    );

    // Data memory with a bench-side write port used while the DUT is idle.
    logic [7:0] mem [256];
    logic       tb_we;
    logic [7:0] tb_addr;
    logic [7:0] tb_data;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
        if (tb_we) mem[tb_addr] <= tb_data;
        else if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int viol     = 0;

    logic [7:0] tap_tab [8] = '{8'he1, 8'hd4, 8'hc6, 8'hb8, 8'hb4, 8'hb2, 8'hfa, 8'hf3};
    logic [7:0] pt_arr [55];
    logic [7:0] ks     [64];
    logic [7:0] exp_ct [64];

    typedef struct {
        int sel;
        int seed;
        int pre;
        int kind;     // 0 quote, 1 all zero
        int exp_cyc;
    } vec_t;

    vec_t vecs [6] = '{
        '{0, 8'h01, 12, 0, 170},
        '{3, 8'h5A,  9, 1, 176},
        '{0, 8'h00, 12, 0, 170},
        '{3, 8'h5A,  3, 1, 176},
        '{5, 8'hC3, 15, 0, 164},
        '{7, 8'h80,  0, 0, 176}
    };

    // Bus rule monitor.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (mem_rd_en && mem_wr_en) viol++;
            if (!mem_wr_en && mem_wdata != 8'd0) viol++;
            if ((mem_rd_en || mem_wr_en) && mem_addr > 8'd127) viol++;
            if (busy && done) viol++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic poke(input int a, input logic [7:0] d);
        @(negedge clk);
        tb_we   = 1'b1;
        tb_addr = 8'(a);
        tb_data = d;
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    task automatic load_taps();
        for (int k = 0; k < 8; k++) poke(55 + k, tap_tab[k]);
    endtask

    task automatic load_msg(input int kind);
        string q;
        q = "Knowledge comes, but wisdom lingers.";
        for (int k = 0; k < 55; k++) begin
            if (kind == 0)      pt_arr[k] = (k < q.len()) ? q[k] : 8'h00;
            else if (kind == 1) pt_arr[k] = 8'h00;
            else                pt_arr[k] = 8'($urandom_range(32, 126));
            poke(k, pt_arr[k]);
        end
    endtask

    task automatic clear_ct();
        for (int k = 0; k < 64; k++) poke(64 + k, 8'h00);
    endtask

    function automatic int eff_pre(input int pre);
        return (pre < 9) ? 9 : pre;
    endfunction

    // Keystream: the successive LFSR states, one per ciphertext byte.
    task automatic gen_ks(input int sel, input int sd);
        int s;
        s = (sd == 0) ? 1 : sd;
        for (int k = 0; k < 64; k++) begin
            ks[k] = 8'(s);
            s = ((s * 2) % 256) + ($countones(s & tap_tab[sel]) % 2);
        end
    endtask

    task automatic build_expected(input int sel, input int sd, input int pre);
        int pe;
        pe = eff_pre(pre);
        gen_ks(sel, sd);
        for (int k = 0; k < 64; k++)
            exp_ct[k] = ((k < pe) ? 8'h20 : pt_arr[k - pe]) ^ ks[k];
    endtask

    task automatic check_ct(input string name);
        int bad;
        bad = 0;
        for (int k = 0; k < 64; k++)
            if (mem[64 + k] !== exp_ct[k]) bad++;
        chk(name, bad, 0);
    endtask

    // Decrypt memory image with the known key and compare to plaintext.
    task automatic check_decrypt(input string name, input int sel, input int sd, input int pre);
        int bad;
        int pe;
        logic [7:0] d;
        bad = 0;
        pe  = eff_pre(pre);
        gen_ks(sel, sd);
        for (int k = 0; k < 64; k++) begin
            d = mem[64 + k] ^ ks[k];
            if (k < pe) begin
                if (d !== 8'h20) bad++;
            end else if (d !== pt_arr[k - pe]) bad++;
        end
        chk(name, bad, 0);
    endtask

    // Issue start, then count rising edges after acceptance until done.
    task automatic run(input int sel, input int sd, input int pre, input int pulse_at,
                       output int cycles);
        @(negedge clk);
        ptrn_sel = 3'(sel);
        seed     = 8'(sd);
        pre_len  = 4'(pre);
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_on_accept", {30'd0, busy, done}, 32'd2);
        cycles = 0;
        while (!done && cycles < 1000) begin
            @(posedge clk);
            #1 cycles++;
            if (cycles == pulse_at) begin
                start    = 1'b1;
                ptrn_sel = ~ptrn_sel;
                seed     = ~8'(sd);
                pre_len  = 4'd15;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    initial begin
        int cyc;
        int sd;
        int pre;
        reset_n  = 1'b0;
        start    = 1'b0;
        ptrn_sel = 3'd0;
        seed     = 8'd0;
        pre_len  = 4'd0;
        tb_we    = 1'b0;
        tb_addr  = 8'd0;
        tb_data  = 8'd0;
        #2;
        chk("reset_outputs", {12'd0, busy, done, mem_rd_en, mem_wr_en, mem_addr, mem_wdata}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        load_taps();

        // Table-driven runs.
        for (int v = 0; v < 6; v++) begin
            load_msg(vecs[v].kind);
            clear_ct();
            build_expected(vecs[v].sel, vecs[v].seed, vecs[v].pre);
            run(vecs[v].sel, vecs[v].seed, vecs[v].pre, -1, cyc);
            chk($sformatf("cycles_vec%0d", v), cyc, vecs[v].exp_cyc);
            check_ct($sformatf("ct_vec%0d", v));
        end

        // Reset asserted mid-run, then a clean rerun of the first vector.
        load_msg(0);
        clear_ct();
        @(negedge clk);
        ptrn_sel = 3'd0; seed = 8'h01; pre_len = 4'd12; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (50) @(posedge clk);
        #1 reset_n = 1'b0;
        #1 chk("abort_outputs", {12'd0, busy, done, mem_rd_en, mem_wr_en, mem_addr, mem_wdata}, 32'd0);
        @(posedge clk);
        #1 chk("abort_outputs_next", {12'd0, busy, done, mem_rd_en, mem_wr_en, mem_addr, mem_wdata}, 32'd0);
        @(negedge clk) reset_n = 1'b1;
        clear_ct();
        build_expected(0, 8'h01, 12);
        run(0, 8'h01, 12, -1, cyc);
        chk("cycles_after_abort", cyc, 170);
        check_ct("ct_after_abort");

        // Start pulsed while busy must be ignored.
        clear_ct();
        build_expected(1, 8'h77, 10);
        run(1, 8'h77, 10, 20, cyc);
        chk("cycles_busy_start", cyc, 174);
        check_ct("ct_busy_start");

        // done stays high, then start in DONE re-arms a new run.
        repeat (3) @(posedge clk);
        #1 chk("done_sticky", {30'd0, busy, done}, 32'd1);
        build_expected(2, 8'h9E, 13);
        run(2, 8'h9E, 13, -1, cyc);
        chk("cycles_rearm", cyc, 168);
        check_ct("ct_rearm");

        // Randomized: every pattern, random seed, random legal preamble.
        for (int p = 0; p < 8; p++) begin
            sd  = int'($urandom_range(0, 255));
            pre = int'($urandom_range(9, 15));
            load_msg(2);
            clear_ct();
            build_expected(p, sd, pre);
            run(p, sd, pre, -1, cyc);
            chk($sformatf("cycles_rand%0d", p), cyc, 2 + pre + 3 * (64 - pre));
            check_ct($sformatf("ct_rand%0d", p));
            check_decrypt($sformatf("decrypt_rand%0d", p), p, sd, pre);
        end

        chk("bus_rules", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
